// File: rtl/picomips_controller.sv
// picomips_controller
//   Multi-cycle sequencer/decoder for the picoMIPS core. Holds the program
//   counter, fetches from synchronous instruction memory, decodes each word
//   into ALU/register-file controls and runs the switch-input and
//   result-output ready/valid handshakes.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr                 instruction word (valid one cycle after pc)
//   a_zero                register rd currently reads zero
//   in_valid, out_ready   handshake inputs from switches / output consumer
//   pc                    instruction memory address
//   alu_func, imm_sel     ALU function code, b-operand select (1 = imm)
//   in_sel, reg_we        write-data select (1 = switches), write enable
//   rd_addr, rs_addr, imm instruction fields, driven in every state
//   in_ready, out_valid   handshake outputs
//   halted, illegal       HALT reached, sticky undefined-opcode flag
module picomips_controller #(
  parameter int N      = 8,
  parameter int A_SIZE = 3,
  parameter int PC_W   = 6,
  parameter int I_W    = 8 + N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [I_W-1:0]    instr,
  input  logic              a_zero,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc,
  output logic [A_SIZE-1:0] alu_func,
  output logic              imm_sel,
  output logic              in_sel,
  output logic              reg_we,
  output logic [1:0]        rd_addr,
  output logic [1:0]        rs_addr,
  output logic [N-1:0]      imm,
  output logic              in_ready,
  output logic              out_valid,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WAIT_IN,
    WAIT_OUT,
    HALT_S
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_MUL  = 4'd3,
    OP_MULI = 4'd4,
    OP_MOV  = 4'd5,
    OP_LDI  = 4'd6,
    OP_IN   = 4'd7,
    OP_BNZ  = 4'd8,
    OP_JMP  = 4'd9,
    OP_OUT  = 4'd10,
    OP_HALT = 4'd11
  } opcode_t;

  localparam logic [A_SIZE-1:0] ALU_A   = A_SIZE'(0);
  localparam logic [A_SIZE-1:0] ALU_B   = A_SIZE'(1);
  localparam logic [A_SIZE-1:0] ALU_ADD = A_SIZE'(2);
  localparam logic [A_SIZE-1:0] ALU_MUL = A_SIZE'(3);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              we_raw;

  opcode_t           opcode;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;

  assign opcode  = opcode_t'(instr[I_W-1 -: 4]);
  assign rd_addr = instr[N+3:N+2];
  assign rs_addr = instr[N+1:N];
  assign imm     = instr[N-1:0];
  // Branch targets keep only the low PC_W bits of the immediate.
  assign target  = instr[PC_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  // A reset cycle must never commit a register write, even mid-handshake.
  assign reg_we  = we_raw & ~reset;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    alu_func  = ALU_A;
    imm_sel   = 1'b0;
    in_sel    = 1'b0;
    we_raw    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      FETCH: state_d = EXEC;

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_NOP: ;
          OP_ADD:  begin alu_func = ALU_ADD; we_raw = 1'b1; end
          OP_ADDI: begin alu_func = ALU_ADD; imm_sel = 1'b1; we_raw = 1'b1; end
          OP_MUL:  begin alu_func = ALU_MUL; we_raw = 1'b1; end
          OP_MULI: begin alu_func = ALU_MUL; imm_sel = 1'b1; we_raw = 1'b1; end
          OP_MOV:  begin alu_func = ALU_B; we_raw = 1'b1; end
          OP_LDI:  begin alu_func = ALU_B; imm_sel = 1'b1; we_raw = 1'b1; end
          OP_IN:   begin state_d = WAIT_IN; pc_d = pc_q; end
          OP_BNZ:  if (!a_zero) pc_d = target;
          OP_JMP:  pc_d = target;
          OP_OUT:  begin state_d = WAIT_OUT; pc_d = pc_q; end
          OP_HALT: begin state_d = HALT_S; pc_d = pc_q; halted_d = 1'b1; end
          default: illegal_d = 1'b1;
        endcase
      end

      WAIT_IN: begin
        in_ready = 1'b1;
        // Write data is taken from the switches on the handshake edge itself.
        in_sel   = in_valid;
        we_raw   = in_valid;
        if (in_valid) begin
          state_d = FETCH;
          pc_d    = pc_inc;
        end
      end

      WAIT_OUT: begin
        out_valid = 1'b1;
        alu_func  = ALU_A;
        if (out_ready) begin
          state_d = FETCH;
          pc_d    = pc_inc;
        end
      end

      HALT_S: ;

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_picomips_controller.sv
// Directed bench for picomips_controller with a synchronous instruction ROM.
module tb_picomips_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr;
  logic        a_zero = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [5:0]  pc;
  logic [2:0]  alu_func;
  logic        imm_sel, in_sel, reg_we;
  logic [1:0]  rd_addr, rs_addr;
  logic [7:0]  imm;
  logic        in_ready, out_valid, halted, illegal;

  logic [15:0] mem [64];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) instr <= mem[pc];

  picomips_controller #(.N(8), .A_SIZE(3), .PC_W(6), .I_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .a_zero(a_zero),
    .in_valid(in_valid), .out_ready(out_ready), .pc(pc),
    .alu_func(alu_func), .imm_sel(imm_sel), .in_sel(in_sel),
    .reg_we(reg_we), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
    .in_ready(in_ready), .out_valid(out_valid), .halted(halted),
    .illegal(illegal)
  );

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] im);
    return {op, rd, rs, im};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  // Leaves the bench at a negedge with reset released and the DUT in FETCH, pc=0.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({pc, halted, illegal, reg_we, in_ready, out_valid, alu_func} !== 14'd0) begin
      fails++;
      $display("FAIL reset_state: got pc=%0d halted=%b illegal=%b we=%b in_ready=%b out_valid=%b alu=%0d, want all 0",
               pc, halted, illegal, reg_we, in_ready, out_valid, alu_func);
    end
    do_reset();
  endtask

  task automatic test_ldi_addi();
    int exp_pc [5] = '{0, 0, 1, 1, 2};
    int exp_we [5] = '{0, 1, 0, 1, 0};
    int we_cnt = 0;
    clear_mem();
    mem[0] = ins(4'd6, 2'd1, 2'd0, 8'd5);
    mem[1] = ins(4'd2, 2'd1, 2'd0, 8'd3);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (pc !== 6'(exp_pc[k])) begin
        fails++; $display("FAIL ldi_addi_pc k=%0d: got %0d want %0d", k, pc, exp_pc[k]);
      end
      tests++;
      if (reg_we !== 1'(exp_we[k])) begin
        fails++; $display("FAIL ldi_addi_we k=%0d: got %b want %0d", k, reg_we, exp_we[k]);
      end
      if (reg_we === 1'b1) we_cnt++;
      if (k == 1) begin
        tests++;
        if ({alu_func, imm_sel, imm, rd_addr} !== {3'd1, 1'b1, 8'd5, 2'd1}) begin
          fails++; $display("FAIL ldi_decode: got alu=%0d imm_sel=%b imm=%h rd=%0d want 1 1 05 1",
                            alu_func, imm_sel, imm, rd_addr);
        end
      end
      if (k == 3) begin
        tests++;
        if ({alu_func, imm_sel, imm} !== {3'd2, 1'b1, 8'h03}) begin
          fails++; $display("FAIL addi_decode: got alu=%0d imm_sel=%b imm=%h want 2 1 03",
                            alu_func, imm_sel, imm);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (we_cnt != 2) begin
      fails++; $display("FAIL ldi_addi_we_count: got %0d want 2", we_cnt);
    end
  endtask

  task automatic test_mul();
    clear_mem();
    mem[4] = ins(4'd3, 2'd2, 2'd3, 8'h00);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      #1;
      tests++;
      if (pc !== 6'(k / 2)) begin
        fails++; $display("FAIL mul_pc k=%0d: got %0d want %0d", k, pc, k / 2);
      end
      if (k == 9) begin
        tests++;
        if ({alu_func, imm_sel, rd_addr, rs_addr, reg_we} !== {3'd3, 1'b0, 2'd2, 2'd3, 1'b1}) begin
          fails++; $display("FAIL mul_decode: got alu=%0d imm_sel=%b rd=%0d rs=%0d we=%b want 3 0 2 3 1",
                            alu_func, imm_sel, rd_addr, rs_addr, reg_we);
        end
      end
      if (k == 10) begin
        tests++;
        if (reg_we !== 1'b0) begin
          fails++; $display("FAIL mul_fetch_we: got %b want 0", reg_we);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_in();
    int ir_cnt = 0;
    clear_mem();
    mem[0] = ins(4'd7, 2'd0, 2'd0, 8'h00);
    mem[1] = ins(4'd7, 2'd2, 2'd0, 8'h00);
    mem[2] = ins(4'd7, 2'd1, 2'd0, 8'h00);
    do_reset();
    for (int k = 0; k < 13; k++) begin
      logic e_ir, e_we;
      int   e_pc;
      in_valid = (k >= 5);
      reset    = (k == 11);
      e_ir = (k >= 2 && k <= 5) || k == 8 || k == 11;
      e_we = (k == 5) || (k == 8);
      e_pc = (k <= 5) ? 0 : (k <= 8) ? 1 : (k <= 11) ? 2 : 0;
      #1;
      if (in_ready === 1'b1 && k <= 6) ir_cnt++;
      tests++;
      if (in_ready !== e_ir) begin
        fails++; $display("FAIL in_ready k=%0d: got %b want %b", k, in_ready, e_ir);
      end
      tests++;
      if (reg_we !== e_we) begin
        fails++; $display("FAIL in_we k=%0d: got %b want %b", k, reg_we, e_we);
      end
      tests++;
      if (pc !== 6'(e_pc)) begin
        fails++; $display("FAIL in_pc k=%0d: got %0d want %0d", k, pc, e_pc);
      end
      if (k >= 2 && k <= 5) begin
        tests++;
        if (in_sel !== (k == 5)) begin
          fails++; $display("FAIL in_sel k=%0d: got %b want %b", k, in_sel, k == 5);
        end
      end
      @(negedge clk);
    end
    reset = 1'b0; in_valid = 1'b0;
    tests++;
    if (ir_cnt != 4) begin
      fails++; $display("FAIL in_ready_count: got %0d want 4", ir_cnt);
    end
  endtask

  task automatic test_out();
    int ov_cnt = 0;
    clear_mem();
    mem[0] = ins(4'd10, 2'd1, 2'd0, 8'h00);
    mem[1] = ins(4'd10, 2'd1, 2'd0, 8'h00);
    do_reset();
    for (int k = 0; k < 13; k++) begin
      logic e_ov;
      int   e_pc;
      out_ready = (k == 7) || (k == 11);
      reset     = (k == 11);
      e_ov = (k >= 2 && k <= 7) || k == 10;
      e_pc = (k <= 7) ? 0 : (k <= 11) ? 1 : 0;
      #1;
      if (out_valid === 1'b1 && k <= 8) ov_cnt++;
      if (k != 11) begin
        tests++;
        if (out_valid !== e_ov) begin
          fails++; $display("FAIL out_valid k=%0d: got %b want %b", k, out_valid, e_ov);
        end
      end
      tests++;
      if (alu_func !== 3'd0) begin
        fails++; $display("FAIL out_alu k=%0d: got %0d want 0", k, alu_func);
      end
      tests++;
      if (pc !== 6'(e_pc)) begin
        fails++; $display("FAIL out_pc k=%0d: got %0d want %0d", k, pc, e_pc);
      end
      @(negedge clk);
    end
    reset = 1'b0; out_ready = 1'b0;
    tests++;
    if (ov_cnt != 6) begin
      fails++; $display("FAIL out_valid_count: got %0d want 6", ov_cnt);
    end
  endtask

  task automatic test_branch();
    int exp_pc [9] = '{0, 0, 42, 42, 43, 43, 63, 63, 0};
    clear_mem();
    mem[0]  = ins(4'd8, 2'd0, 2'd0, 8'hEA);
    mem[42] = ins(4'd8, 2'd0, 2'd0, 8'h2A);
    mem[43] = ins(4'd9, 2'd0, 2'd0, 8'h3F);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      a_zero = (k >= 3);
      #1;
      tests++;
      if (pc !== 6'(exp_pc[k])) begin
        fails++; $display("FAIL branch_pc k=%0d: got %0d want %0d", k, pc, exp_pc[k]);
      end
      tests++;
      if (reg_we !== 1'b0) begin
        fails++; $display("FAIL branch_we k=%0d: got %b want 0", k, reg_we);
      end
      @(negedge clk);
    end
    a_zero = 1'b0;
  endtask

  task automatic test_illegal_halt();
    clear_mem();
    mem[0] = ins(4'd14, 2'd1, 2'd2, 8'h55);
    mem[2] = ins(4'd11, 2'd0, 2'd0, 8'h00);
    do_reset();
    for (int k = 0; k < 27; k++) begin
      int e_pc;
      e_pc = (k <= 1) ? 0 : (k <= 3) ? 1 : 2;
      #1;
      tests++;
      if (pc !== 6'(e_pc)) begin
        fails++; $display("FAIL halt_pc k=%0d: got %0d want %0d", k, pc, e_pc);
      end
      tests++;
      if (illegal !== (k >= 2)) begin
        fails++; $display("FAIL illegal k=%0d: got %b want %b", k, illegal, k >= 2);
      end
      tests++;
      if (halted !== (k >= 6)) begin
        fails++; $display("FAIL halted k=%0d: got %b want %b", k, halted, k >= 6);
      end
      tests++;
      if (reg_we !== 1'b0) begin
        fails++; $display("FAIL illegal_we k=%0d: got %b want 0", k, reg_we);
      end
      @(negedge clk);
    end
    do_reset();
    #1;
    tests++;
    if ({halted, illegal, pc} !== 8'd0) begin
      fails++; $display("FAIL halt_reset: got halted=%b illegal=%b pc=%0d want 0 0 0", halted, illegal, pc);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    clear_mem();
    test_reset();
    test_ldi_addi();
    test_mul();
    test_in();
    test_out();
    test_branch();
    test_illegal_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
